// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : 8N1 serial transmitter fed by a 4-entry byte FIFO
// Revision: 1.0
// ============================================================================
module uart_tx #(
   parameter logic [9:0] BAUD_DIVISOR = 10'd868
) (
   input  logic       clk100,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic [2:0] fifo_level
);

   localparam logic [9:0] C_BIT_LAST = BAUD_DIVISOR - 10'd1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t     state_q,   state_d;
   logic [9:0] timer_q,   timer_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shift_q,   shift_d;
   logic       tx_q,      tx_d;
   logic [7:0] mem_q [4];
   logic [7:0] mem_d [4];
   logic [1:0] wr_ptr_q,  wr_ptr_d;
   logic [1:0] rd_ptr_q,  rd_ptr_d;
   logic [2:0] level_q,   level_d;

   logic       w_push;
   logic       w_pop;
   logic       w_bit_end;

   // Ready depends only on the registered level, never on tx_valid.
   assign tx_ready   = (level_q != 3'd4);
   assign tx         = tx_q;
   assign fifo_level = level_q;
   assign tx_busy    = (state_q != ST_IDLE) || (level_q != 3'd0);

   assign w_push    = tx_valid && tx_ready;
   assign w_bit_end = (timer_q == 10'd0);

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      w_pop     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (level_q != 3'd0) begin
               w_pop   = 1'b1;
               state_d = ST_START;
               timer_d = C_BIT_LAST;
               shift_d = mem_q[rd_ptr_q];
               tx_d    = 1'b0;
            end
         end
         ST_START: begin
            if (w_bit_end) begin
               state_d   = ST_DATA;
               bit_idx_d = 3'd0;
               timer_d   = C_BIT_LAST;
               tx_d      = shift_q[0];
            end else begin
               timer_d = timer_q - 10'd1;
            end
         end
         ST_DATA: begin
            if (w_bit_end) begin
               timer_d = C_BIT_LAST;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end else begin
               timer_d = timer_q - 10'd1;
            end
         end
         ST_STOP: begin
            if (w_bit_end) begin
               // Chain straight into the next start bit when more data waits.
               if (level_q != 3'd0) begin
                  w_pop   = 1'b1;
                  state_d = ST_START;
                  timer_d = C_BIT_LAST;
                  shift_d = mem_q[rd_ptr_q];
                  tx_d    = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  timer_d = 10'd0;
                  tx_d    = 1'b1;
               end
            end else begin
               timer_d = timer_q - 10'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = 10'd0;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (w_push) begin
         mem_d[wr_ptr_q] = tx_data;
      end
      wr_ptr_d = wr_ptr_q + {1'b0, w_push};
      rd_ptr_d = rd_ptr_q + {1'b0, w_pop};
      level_d  = level_q + {2'b00, w_push} - {2'b00, w_pop};
   end

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         timer_q   <= 10'd0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         tx_q      <= 1'b1;
         mem_q     <= '{default: 8'h00};
         wr_ptr_q  <= 2'd0;
         rd_ptr_q  <= 2'd0;
         level_q   <= 3'd0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_tx : scoreboard bench for uart_tx (divisor 4, plus a divisor-868 copy)
// Revision: 1.0
// ============================================================================
module tb_uart_tx;

   localparam int DIV = 4;

   logic       clk100 = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic [2:0] fifo_level;

   logic [7:0] tx_data2;
   logic       tx_valid2;
   logic       tx_ready2;
   logic       tx2;
   logic       tx_busy2;
   logic [2:0] fifo_level2;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc   = 0;
   logic [7:0] exp_q [$];
   int         starts [$];

   always #5 clk100 = ~clk100;
   always @(posedge clk100) cyc <= cyc + 1;

   uart_tx #(.BAUD_DIVISOR(10'd4)) u_dut (
      .clk100     (clk100),
      .rst_n      (rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx         (tx),
      .tx_busy    (tx_busy),
      .fifo_level (fifo_level)
   );

   uart_tx #(.BAUD_DIVISOR(10'd868)) u_dut_868 (
      .clk100     (clk100),
      .rst_n      (rst_n),
      .tx_data    (tx_data2),
      .tx_valid   (tx_valid2),
      .tx_ready   (tx_ready2),
      .tx         (tx2),
      .tx_busy    (tx_busy2),
      .fifo_level (fifo_level2)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Call at a negedge; returns at the negedge after the accepting edge, valid still high.
   task automatic send(input logic [7:0] b, output int waited);
      logic ok;
      waited   = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && waited < 200) begin
         @(negedge clk100);
         waited++;
      end
      ok = tx_ready;
      check_eq("accept_ready", {31'd0, tx_ready}, 32'd1);
      @(posedge clk100);
      if (ok) exp_q.push_back(b);
      @(negedge clk100);
      tx_data = 8'($urandom);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (tx_busy && n < budget) begin
         @(negedge clk100);
         n++;
      end
      check_eq("idle_within_budget", {31'd0, tx_busy}, 32'd0);
   endtask

   task automatic check_gaps(input string tag, input int n_frames);
      check_eq({tag, "_frames"}, starts.size(), n_frames);
      for (int i = 1; i < starts.size(); i++) begin
         check_eq({tag, "_gap"}, starts[i] - starts[i-1], 10 * DIV);
      end
   endtask

   // Serial-line monitor: decodes every frame and checks it against the scoreboard.
   initial begin : p_mon
      int         cnt;
      logic [9:0] frame;
      logic       glitch;
      logic       act;
      logic [7:0] exp;
      act    = 1'b0;
      cnt    = 0;
      frame  = '0;
      glitch = 1'b0;
      forever begin
         @(negedge clk100);
         if (!rst_n) begin
            act = 1'b0;
         end else begin
            if (!act && tx === 1'b0) begin
               act    = 1'b1;
               cnt    = 0;
               glitch = 1'b0;
               frame  = '0;
               starts.push_back(cyc);
            end
            if (act) begin
               if (cnt % DIV == 0) frame[cnt / DIV] = tx;
               else if (tx !== frame[cnt / DIV]) glitch = 1'b1;
               cnt++;
               if (cnt == 10 * DIV) begin
                  act = 1'b0;
                  check_eq("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                  if (exp_q.size() != 0) begin
                     exp = exp_q.pop_front();
                     check_eq("frame_data", {24'd0, frame[8:1]}, {24'd0, exp});
                  end
                  check_eq("start_bit", {31'd0, frame[0]}, 32'd0);
                  check_eq("stop_bit", {31'd0, frame[9]}, 32'd1);
                  check_eq("bit_stable", {31'd0, glitch}, 32'd0);
               end
            end
         end
      end
   end

   initial begin : p_watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, got hang expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : p_main
      int w;
      int n;
      int c0;
      int len;
      rst_n     = 1'b0;
      tx_data   = 8'h00;
      tx_valid  = 1'b0;
      tx_data2  = 8'h00;
      tx_valid2 = 1'b0;

      // Reset state
      repeat (3) @(negedge clk100);
      check_eq("rst_tx",    {31'd0, tx},        32'd1);
      check_eq("rst_ready", {31'd0, tx_ready},  32'd1);
      check_eq("rst_busy",  {31'd0, tx_busy},   32'd0);
      check_eq("rst_level", {29'd0, fifo_level}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk100);

      // Single byte 0xA5: one-cycle latency, 40-cycle frame
      starts.delete();
      send(8'hA5, w);
      tx_valid = 1'b0;
      check_eq("a5_level_after_accept", {29'd0, fifo_level}, 32'd1);
      check_eq("a5_tx_before_pop",      {31'd0, tx},         32'd1);
      check_eq("a5_busy",               {31'd0, tx_busy},    32'd1);
      @(negedge clk100);
      check_eq("a5_tx_fall_latency",    {31'd0, tx},         32'd0);
      check_eq("a5_level_after_pop",    {29'd0, fifo_level}, 32'd0);
      wait_idle(200);
      check_eq("a5_frames", starts.size(), 1);
      if (starts.size() != 0) check_eq("a5_busy_len", cyc - starts[0], 40);
      repeat (3) @(negedge clk100);

      // Five writes with valid held, then a sixth held while full
      starts.delete();
      for (int i = 1; i <= 5; i++) send(8'(i), w);
      check_eq("burst_level_full", {29'd0, fifo_level}, 32'd4);
      check_eq("burst_ready_low",  {31'd0, tx_ready},   32'd0);
      tx_data = 8'h06;
      repeat (3) @(negedge clk100);
      check_eq("burst_level_held", {29'd0, fifo_level}, 32'd4);
      send(8'h06, w);
      tx_valid = 1'b0;
      wait_idle(600);
      check_gaps("burst", 6);
      repeat (3) @(negedge clk100);

      // Enqueue on the same edge as the STOP-end pop with two bytes queued
      starts.delete();
      send(8'h3C, w);
      send(8'hC3, w);
      send(8'h96, w);
      tx_valid = 1'b0;
      check_eq("sim_level_before", {29'd0, fifo_level}, 32'd2);
      repeat (38) @(negedge clk100);
      send(8'h69, w);
      tx_valid = 1'b0;
      check_eq("sim_level_after", {29'd0, fifo_level}, 32'd2);
      wait_idle(400);
      check_gaps("sim", 4);
      repeat (3) @(negedge clk100);

      // Reset 10 cycles into a frame of 0x00 with three bytes queued
      send(8'h00, w);
      send(8'h11, w);
      send(8'h22, w);
      send(8'h33, w);
      tx_valid = 1'b0;
      check_eq("abort_level_before", {29'd0, fifo_level}, 32'd3);
      repeat (7) @(negedge clk100);
      check_eq("abort_tx_before", {31'd0, tx}, 32'd0);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_eq("abort_tx",    {31'd0, tx},         32'd1);
      check_eq("abort_level", {29'd0, fifo_level}, 32'd0);
      check_eq("abort_ready", {31'd0, tx_ready},   32'd1);
      check_eq("abort_busy",  {31'd0, tx_busy},    32'd0);
      @(negedge clk100);
      rst_n = 1'b1;
      starts.delete();
      repeat (100) @(negedge clk100);
      check_eq("abort_no_frames", starts.size(), 0);
      check_eq("abort_quiet_tx",  {31'd0, tx},      32'd1);
      check_eq("abort_quiet_busy", {31'd0, tx_busy}, 32'd0);

      // Fresh reset, enqueue on first edge, then 0x00 and 0xFF back-to-back
      #2;
      rst_n = 1'b0;
      @(negedge clk100);
      rst_n = 1'b1;
      starts.delete();
      send(8'h00, w);
      check_eq("first_edge_accept", w, 0);
      send(8'hFF, w);
      tx_valid = 1'b0;
      wait_idle(300);
      check_gaps("zf", 2);
      if (starts.size() != 0) check_eq("zf_total_len", cyc - starts[0], 80);
      repeat (3) @(negedge clk100);

      // Divisor 868, byte 0x55: every bit exactly 868 cycles
      tx_data2  = 8'h55;
      tx_valid2 = 1'b1;
      @(posedge clk100);
      @(negedge clk100);
      tx_valid2 = 1'b0;
      tx_data2  = 8'hAA;
      n = 0;
      while (tx2 !== 1'b0 && n < 10) begin
         @(negedge clk100);
         n++;
      end
      check_eq("d868_start_latency", n, 1);
      c0 = cyc;
      for (int r = 0; r < 9; r++) begin
         len = 0;
         while (tx2 === r[0] && len < 2000) begin
            len++;
            @(negedge clk100);
         end
         check_eq("d868_bit_len", len, 868);
      end
      n = 0;
      while (tx_busy2 && n < 2000) begin
         @(negedge clk100);
         n++;
      end
      check_eq("d868_frame_len", cyc - c0, 8680);
      check_eq("d868_tx_idle",   {31'd0, tx2}, 32'd1);

      check_eq("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
